// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//   Run/pause/lap/clear sequencer for a centisecond stopwatch counter.
//   Debounces the start/stop and lap/clear buttons, generates the count
//   strobe while running, issues the counter clear and freezes a lap time
//   on the display outputs.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          asynchronous active-high reset
//   btn_ss       raw start/stop button (async, active-high)
//   btn_lap      raw lap/clear button (async, active-high)
//   minute_in    live minute from the counter
//   second_in    live second from the counter
//   msecond_in   live centisecond from the counter
//   tick_out     1-cycle count strobe to the counter
//   clr_n        counter clear, active-low
//   disp_minute  displayed minute (live or lap)
//   disp_second  displayed second (live or lap)
//   disp_msec    displayed centisecond (live or lap)
//   running      high in RUN or LAP
//   lap_active   high in LAP (display frozen)
//
// Parameters
//   TICK_DIV     clk cycles per count strobe (>= 2)
//   DEB_LEN      consecutive equal synchronised samples needed to accept a
//                new button level (>= 1)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// stopwatch_ctrl_debounce
//   Two-flop synchroniser, stability down-counter and rising-edge pulse.
//   The accepted level flips once DEB_LEN consecutive synchronised samples
//   disagree with it; press is a registered 1-cycle pulse on a 0->1 flip,
//   so a raw edge shows up as press 2 + DEB_LEN + 1 cycles later.
//
// Ports
//   clk    system clock
//   rst    asynchronous active-high reset
//   btn    raw button input
//   press  1-cycle pulse per accepted press
// ---------------------------------------------------------------------------
module stopwatch_ctrl_debounce #(
    parameter int DEB_LEN = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DEB_LEN - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Any sample agreeing with the accepted level restarts the count, so only
    // an unbroken run of DEB_LEN disagreeing samples reaches terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level      <= 1'b0;
            stable_cnt <= RELOAD;
        end else if (sync2 == level) begin
            stable_cnt <= RELOAD;
        end else if (stable_cnt == '0) begin
            level      <= sync2;
            stable_cnt <= RELOAD;
        end else begin
            stable_cnt <= stable_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_q <= level;
            press   <= level & ~level_q;
        end
    end

endmodule

// ---------------------------------------------------------------------------
// FSM states
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | stopped and cleared, prescaler at 0, display live
//   ST_RUN   | counting, ticks issued, display live
//   ST_LAP   | counting, ticks issued, display frozen on lap registers
//   ST_PAUSE | stopped, prescaler holds its partial interval, display live
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int TICK_DIV = 500000,
    parameter int DEB_LEN  = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic [7:0] minute_in,
    input  logic [7:0] second_in,
    input  logic [7:0] msecond_in,
    output logic       tick_out,
    output logic       clr_n,
    output logic [7:0] disp_minute,
    output logic [7:0] disp_second,
    output logic [7:0] disp_msec,
    output logic       running,
    output logic       lap_active
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          ss_press;
    logic          lap_press;
    logic          clr_req;
    logic          lap_cap;
    logic          counting;
    logic [PW-1:0] pre_cnt;
    logic [7:0]    lap_minute;
    logic [7:0]    lap_second;
    logic [7:0]    lap_msec;

    stopwatch_ctrl_debounce #(.DEB_LEN(DEB_LEN)) u_deb_ss (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_ss),
        .press (ss_press)
    );

    stopwatch_ctrl_debounce #(.DEB_LEN(DEB_LEN)) u_deb_lap (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_lap),
        .press (lap_press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Start/stop is checked first in every state, so a lap press landing in
    // the same cycle is simply dropped.
    always_comb begin
        state_nxt = state;
        clr_req   = 1'b0;
        lap_cap   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ss_press) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ss_press) begin
                    state_nxt = ST_PAUSE;
                end else if (lap_press) begin
                    state_nxt = ST_LAP;
                    lap_cap   = 1'b1;
                end
            end
            ST_LAP: begin
                if (ss_press) begin
                    state_nxt = ST_PAUSE;
                end else if (lap_press) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (ss_press) begin
                    state_nxt = ST_RUN;
                end else if (lap_press) begin
                    state_nxt = ST_IDLE;
                    clr_req   = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign counting = (state == ST_RUN) || (state == ST_LAP);

    // clr_n resets low so the counter is held clear through reset and is
    // released on the first edge afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_n <= 1'b0;
        end else begin
            clr_n <= ~clr_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_minute <= 8'd0;
            lap_second <= 8'd0;
            lap_msec   <= 8'd0;
        end else if (lap_cap) begin
            lap_minute <= minute_in;
            lap_second <= second_in;
            lap_msec   <= msecond_in;
        end
    end

    // Prescaler only advances while counting; in PAUSE it keeps the partial
    // interval so a resume finishes the interrupted 10 ms slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt  <= '0;
            tick_out <= 1'b0;
        end else if (state_nxt == ST_IDLE) begin
            pre_cnt  <= '0;
            tick_out <= 1'b0;
        end else if (counting) begin
            if (pre_cnt == PRE_LAST) begin
                pre_cnt  <= '0;
                tick_out <= 1'b1;
            end else begin
                pre_cnt  <= pre_cnt + 1'b1;
                tick_out <= 1'b0;
            end
        end else begin
            tick_out <= 1'b0;
        end
    end

    assign running     = counting;
    assign lap_active  = (state == ST_LAP);
    assign disp_minute = lap_active ? lap_minute : minute_in;
    assign disp_second = lap_active ? lap_second : second_in;
    assign disp_msec   = lap_active ? lap_msec   : msecond_in;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4, DEB_LEN=3. A behavioural model
// (raw-sample history, run-length debounce, modulo tick count) tracks the
// expected outputs edge by edge.
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 4;
    localparam int DEB_LEN  = 3;
    localparam int HL       = DEB_LEN + 2;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_LAP   = 2;
    localparam int S_PAUSE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_ss = 1'b0;
    logic       btn_lap = 1'b0;
    logic [7:0] minute_in = 8'd0;
    logic [7:0] second_in = 8'd0;
    logic [7:0] msecond_in = 8'd0;
    logic       tick_out;
    logic       clr_n;
    logic [7:0] disp_minute;
    logic [7:0] disp_second;
    logic [7:0] disp_msec;
    logic       running;
    logic       lap_active;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int       m_state;
    int       m_acc;
    bit       m_tick;
    bit       m_clr_n;
    bit [7:0] m_lap_min;
    bit [7:0] m_lap_sec;
    bit [7:0] m_lap_ms;
    bit       ss_hist[$];
    bit       lap_hist[$];
    bit       m_deb_ss, m_deb_ss_old, m_p_ss;
    bit       m_deb_lap, m_deb_lap_old, m_p_lap;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEB_LEN(DEB_LEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_ss      (btn_ss),
        .btn_lap     (btn_lap),
        .minute_in   (minute_in),
        .second_in   (second_in),
        .msecond_in  (msecond_in),
        .tick_out    (tick_out),
        .clr_n       (clr_n),
        .disp_minute (disp_minute),
        .disp_second (disp_second),
        .disp_msec   (disp_msec),
        .running     (running),
        .lap_active  (lap_active)
    );

    // History holds the raw level sampled at the last HL edges (oldest first).
    // The level seen by the debouncer at an edge is the raw level two edges
    // earlier; it is accepted once the last DEB_LEN such samples all agree.
    function automatic bit deb_eval(input bit h[$], input bit cur);
        bit v;
        v = h[HL-3];
        for (int k = 1; k < DEB_LEN; k++) begin
            if (h[HL-3-k] != v) return cur;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE;
        m_acc = 0;
        m_tick = 1'b0;
        m_clr_n = 1'b0;
        m_lap_min = 8'd0;
        m_lap_sec = 8'd0;
        m_lap_ms = 8'd0;
        m_deb_ss = 1'b0; m_deb_ss_old = 1'b0; m_p_ss = 1'b0;
        m_deb_lap = 1'b0; m_deb_lap_old = 1'b0; m_p_lap = 1'b0;
        ss_hist.delete();
        lap_hist.delete();
        for (int i = 0; i < HL; i++) begin
            ss_hist.push_back(1'b0);
            lap_hist.push_back(1'b0);
        end
    endtask

    task automatic model_edge();
        int nxt;
        bit clr;
        if (rst) begin
            model_reset();
            return;
        end
        nxt = m_state;
        clr = 1'b0;
        case (m_state)
            S_IDLE:  if (m_p_ss) nxt = S_RUN;
            S_RUN: begin
                if (m_p_ss) nxt = S_PAUSE;
                else if (m_p_lap) begin
                    nxt = S_LAP;
                    m_lap_min = minute_in;
                    m_lap_sec = second_in;
                    m_lap_ms = msecond_in;
                end
            end
            S_LAP: begin
                if (m_p_ss) nxt = S_PAUSE;
                else if (m_p_lap) nxt = S_RUN;
            end
            default: begin
                if (m_p_ss) nxt = S_RUN;
                else if (m_p_lap) begin
                    nxt = S_IDLE;
                    clr = 1'b1;
                end
            end
        endcase
        if (m_state == S_RUN || m_state == S_LAP) begin
            m_acc++;
            m_tick = ((m_acc % TICK_DIV) == 0);
        end else begin
            m_tick = 1'b0;
        end
        m_state = nxt;
        if (nxt == S_IDLE) m_acc = 0;
        m_clr_n = !clr;

        ss_hist.push_back(btn_ss);
        void'(ss_hist.pop_front());
        lap_hist.push_back(btn_lap);
        void'(lap_hist.pop_front());
        m_p_ss = m_deb_ss && !m_deb_ss_old;
        m_deb_ss_old = m_deb_ss;
        m_deb_ss = deb_eval(ss_hist, m_deb_ss);
        m_p_lap = m_deb_lap && !m_deb_lap_old;
        m_deb_lap_old = m_deb_lap;
        m_deb_lap = deb_eval(lap_hist, m_deb_lap);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    // Raise the chosen buttons for 4 edges then release; returns right after
    // the 6th edge, when the debounced press pulse is visible.
    task automatic press(input bit ss, input bit lap);
        btn_ss = ss;
        btn_lap = lap;
        repeat (4) step();
        btn_ss = 1'b0;
        btn_lap = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        minute_in = 8'd12; second_in = 8'd34; msecond_in = 8'd56;
        model_reset();
        repeat (3) step();
        n_checks++;
        if (clr_n !== 1'b0) begin n_fail++; $display("FAIL reset_clr_n: got %b expected 0", clr_n); end
        n_checks++;
        if (tick_out !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", tick_out); end
        n_checks++;
        if (running !== 1'b0 || lap_active !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: running=%b lap_active=%b expected 0 0", running, lap_active);
        end
        n_checks++;
        if (disp_minute !== 8'd12 || disp_second !== 8'd34 || disp_msec !== 8'd56) begin
            n_fail++; $display("FAIL reset_disp: got %0d:%0d.%0d expected 12:34.56", disp_minute, disp_second, disp_msec);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (clr_n !== 1'b0) begin n_fail++; $display("FAIL release_clr_n_before_edge: got %b expected 0", clr_n); end
        step();
        n_checks++;
        if (clr_n !== 1'b1) begin n_fail++; $display("FAIL release_clr_n_after_edge: got %b expected 1", clr_n); end
        n_checks++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL release_running: got %b expected 0", running); end
    endtask

    task automatic test_start();
        btn_ss = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 10) btn_ss = 1'b0;
            n_checks++;
            if (running !== (k >= 7)) begin
                n_fail++; $display("FAIL start_running k=%0d: got %b expected %b", k, running, (k >= 7));
            end
            n_checks++;
            if (tick_out !== (k > 7 && ((k - 7) % TICK_DIV) == 0)) begin
                n_fail++; $display("FAIL start_tick k=%0d: got %b expected %b", k, tick_out, (k > 7 && ((k - 7) % TICK_DIV) == 0));
            end
            n_checks++;
            if (lap_active !== 1'b0 || clr_n !== 1'b1) begin
                n_fail++; $display("FAIL start_aux k=%0d: lap_active=%b clr_n=%b expected 0 1", k, lap_active, clr_n);
            end
        end
    endtask

    task automatic test_glitch();
        int last_tick;
        last_tick = -1;
        btn_ss = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 2) btn_ss = 1'b0;
            n_checks++;
            if (running !== 1'b1 || lap_active !== 1'b0) begin
                n_fail++; $display("FAIL glitch_state k=%0d: running=%b lap_active=%b expected 1 0", k, running, lap_active);
            end
            n_checks++;
            if (tick_out !== m_tick) begin
                n_fail++; $display("FAIL glitch_tick k=%0d: got %b expected %b", k, tick_out, m_tick);
            end
            if (tick_out === 1'b1) begin
                if (last_tick >= 0) begin
                    n_checks++;
                    if (k - last_tick != TICK_DIV) begin
                        n_fail++; $display("FAIL glitch_cadence k=%0d: spacing %0d expected %0d", k, k - last_tick, TICK_DIV);
                    end
                end
                last_tick = k;
            end
        end
    endtask

    task automatic test_lap();
        minute_in = 8'd1; second_in = 8'd23; msecond_in = 8'd45;
        press(1'b0, 1'b1);
        step();
        n_checks++;
        if (lap_active !== 1'b1 || running !== 1'b1) begin
            n_fail++; $display("FAIL lap_enter: lap_active=%b running=%b expected 1 1", lap_active, running);
        end
        for (int k = 0; k < 8; k++) begin
            minute_in = 8'($urandom); second_in = 8'($urandom); msecond_in = 8'($urandom);
            step();
            n_checks++;
            if (disp_minute !== 8'd1 || disp_second !== 8'd23 || disp_msec !== 8'd45) begin
                n_fail++; $display("FAIL lap_frozen k=%0d: got %0d:%0d.%0d expected 1:23.45", k, disp_minute, disp_second, disp_msec);
            end
            n_checks++;
            if (tick_out !== m_tick) begin
                n_fail++; $display("FAIL lap_tick k=%0d: got %b expected %b", k, tick_out, m_tick);
            end
        end
        press(1'b0, 1'b1);
        step();
        n_checks++;
        if (lap_active !== 1'b0 || running !== 1'b1) begin
            n_fail++; $display("FAIL lap_exit: lap_active=%b running=%b expected 0 1", lap_active, running);
        end
        minute_in = 8'd59; second_in = 8'd58; msecond_in = 8'd97;
        #1;
        n_checks++;
        if (disp_minute !== 8'd59 || disp_second !== 8'd58 || disp_msec !== 8'd97) begin
            n_fail++; $display("FAIL lap_live: got %0d:%0d.%0d expected 59:58.97", disp_minute, disp_second, disp_msec);
        end
    endtask

    task automatic test_pause_resume_clear();
        int tgt;
        // Pause lands 7 edges after the raw press and counts on that edge,
        // so start when the phase is 7 short of 2 (mod TICK_DIV).
        tgt = (2 - 7 + 4 * TICK_DIV) % TICK_DIV;
        for (int i = 0; i < TICK_DIV; i++) begin
            if ((m_acc % TICK_DIV) != tgt) step();
        end
        press(1'b1, 1'b0);
        step();
        n_checks++;
        if (running !== 1'b0 || lap_active !== 1'b0) begin
            n_fail++; $display("FAIL pause_enter: running=%b lap_active=%b expected 0 0", running, lap_active);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            n_checks++;
            if (tick_out !== 1'b0) begin n_fail++; $display("FAIL pause_no_tick k=%0d: got %b expected 0", k, tick_out); end
        end
        press(1'b1, 1'b0);
        step();
        n_checks++;
        if (running !== 1'b1 || tick_out !== 1'b0) begin
            n_fail++; $display("FAIL resume_enter: running=%b tick=%b expected 1 0", running, tick_out);
        end
        step();
        n_checks++;
        if (tick_out !== 1'b0) begin n_fail++; $display("FAIL resume_tick_early: got %b expected 0", tick_out); end
        step();
        n_checks++;
        if (tick_out !== 1'b1) begin n_fail++; $display("FAIL resume_tick_2: got %b expected 1", tick_out); end
        press(1'b1, 1'b0);
        step();
        n_checks++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL pause2_enter: running=%b expected 0", running); end
        press(1'b0, 1'b1);
        n_checks++;
        if (clr_n !== 1'b1) begin n_fail++; $display("FAIL clear_before: clr_n=%b expected 1", clr_n); end
        step();
        n_checks++;
        if (clr_n !== 1'b0 || running !== 1'b0 || lap_active !== 1'b0) begin
            n_fail++; $display("FAIL clear_pulse: clr_n=%b running=%b lap_active=%b expected 0 0 0", clr_n, running, lap_active);
        end
        step();
        n_checks++;
        if (clr_n !== 1'b1) begin n_fail++; $display("FAIL clear_width: clr_n=%b expected 1", clr_n); end
        for (int k = 0; k < 12; k++) begin
            step();
            n_checks++;
            if (tick_out !== 1'b0 || running !== 1'b0 || clr_n !== 1'b1) begin
                n_fail++; $display("FAIL idle_quiet k=%0d: tick=%b running=%b clr_n=%b expected 0 0 1", k, tick_out, running, clr_n);
            end
        end
        press(1'b1, 1'b0);
        step();
        for (int k = 1; k <= TICK_DIV; k++) begin
            step();
            n_checks++;
            if (tick_out !== (k == TICK_DIV)) begin
                n_fail++; $display("FAIL restart_tick k=%0d: got %b expected %b", k, tick_out, (k == TICK_DIV));
            end
        end
    endtask

    task automatic test_simultaneous();
        press(1'b1, 1'b1);
        step();
        n_checks++;
        if (running !== 1'b0 || lap_active !== 1'b0) begin
            n_fail++; $display("FAIL both_press: running=%b lap_active=%b expected 0 0", running, lap_active);
        end
        minute_in = 8'd3; second_in = 8'd4; msecond_in = 8'd5;
        step();
        n_checks++;
        if (disp_minute !== 8'd3 || disp_second !== 8'd4 || disp_msec !== 8'd5 || clr_n !== 1'b1) begin
            n_fail++; $display("FAIL both_disp: got %0d:%0d.%0d clr_n=%b expected 3:4.5 clr_n=1", disp_minute, disp_second, disp_msec, clr_n);
        end
    endtask

    task automatic test_rst_mid_lap();
        press(1'b1, 1'b0);
        step();
        minute_in = 8'd7; second_in = 8'd8; msecond_in = 8'd9;
        press(1'b0, 1'b1);
        step();
        minute_in = 8'd20; second_in = 8'd21; msecond_in = 8'd22;
        #1;
        n_checks++;
        if (lap_active !== 1'b1 || disp_minute !== 8'd7 || disp_second !== 8'd8 || disp_msec !== 8'd9) begin
            n_fail++; $display("FAIL rst_setup_lap: lap_active=%b disp=%0d:%0d.%0d expected 1 7:8.9", lap_active, disp_minute, disp_second, disp_msec);
        end
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (running !== 1'b0 || lap_active !== 1'b0 || tick_out !== 1'b0 || clr_n !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: running=%b lap_active=%b tick=%b clr_n=%b expected 0 0 0 0", running, lap_active, tick_out, clr_n);
        end
        n_checks++;
        if (disp_minute !== 8'd20 || disp_second !== 8'd21 || disp_msec !== 8'd22) begin
            n_fail++; $display("FAIL rst_disp: got %0d:%0d.%0d expected 20:21.22", disp_minute, disp_second, disp_msec);
        end
        repeat (2) step();
        n_checks++;
        if (tick_out !== 1'b0 || clr_n !== 1'b0) begin
            n_fail++; $display("FAIL rst_hold: tick=%b clr_n=%b expected 0 0", tick_out, clr_n);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (clr_n !== 1'b1 || running !== 1'b0) begin
            n_fail++; $display("FAIL rst_release: clr_n=%b running=%b expected 1 0", clr_n, running);
        end
    endtask

    task automatic test_random();
        int ss_left;
        int lap_left;
        bit exp_run;
        ss_left = 0;
        lap_left = 0;
        for (int c = 0; c < 1500; c++) begin
            if (ss_left == 0) begin
                btn_ss = ($urandom_range(0, 2) == 0);
                ss_left = $urandom_range(1, 8);
            end
            if (lap_left == 0) begin
                btn_lap = ($urandom_range(0, 2) == 0);
                lap_left = $urandom_range(1, 8);
            end
            ss_left--;
            lap_left--;
            rst = ($urandom_range(0, 599) == 0);
            minute_in = 8'($urandom); second_in = 8'($urandom); msecond_in = 8'($urandom);
            step();
            exp_run = (m_state == S_RUN) || (m_state == S_LAP);
            n_checks++;
            if (running !== exp_run || lap_active !== (m_state == S_LAP)) begin
                n_fail++; $display("FAIL rand_state c=%0d: running=%b lap_active=%b expected %b %b", c, running, lap_active, exp_run, (m_state == S_LAP));
            end
            n_checks++;
            if (tick_out !== m_tick || clr_n !== m_clr_n) begin
                n_fail++; $display("FAIL rand_strobes c=%0d: tick=%b clr_n=%b expected %b %b", c, tick_out, clr_n, m_tick, m_clr_n);
            end
            n_checks++;
            if (m_state == S_LAP) begin
                if (disp_minute !== m_lap_min || disp_second !== m_lap_sec || disp_msec !== m_lap_ms) begin
                    n_fail++; $display("FAIL rand_disp_lap c=%0d: got %0d:%0d.%0d expected %0d:%0d.%0d", c, disp_minute, disp_second, disp_msec, m_lap_min, m_lap_sec, m_lap_ms);
                end
            end else if (disp_minute !== minute_in || disp_second !== second_in || disp_msec !== msecond_in) begin
                n_fail++; $display("FAIL rand_disp_live c=%0d: got %0d:%0d.%0d expected %0d:%0d.%0d", c, disp_minute, disp_second, disp_msec, minute_in, second_in, msecond_in);
            end
        end
        rst = 1'b0;
        btn_ss = 1'b0;
        btn_lap = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_glitch();
        test_lap();
        test_pause_resume_clear();
        test_simultaneous();
        test_rst_mid_lap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "time limit");
    end

endmodule
